// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant scheduler and its picker.
// Both build flavours share this package.
package rr_grant_pkg;

  localparam int MAX_N  = 16;
  localparam int MAX_IW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Returns the first set bit at or after ptr, scanning upward and wrapping at n.
  // The result is 0 when vec has no set bit in [0, n).
  function automatic int first_from(input logic [MAX_N-1:0] vec, input int ptr, input int n);
    int  idx;
    int  j;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !found && vec[j[MAX_IW-1:0]]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
// The mask signal exists only in the DEFINE_A build.
interface rr_grant_scheduler_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);

  logic [N-1:0]  i_req;
  logic [N-1:0]  i_done;
`ifdef DEFINE_A
  logic [N-1:0]  i_mask;
`endif
  logic [N-1:0]  o_grant;
  logic [IW-1:0] o_grant_id;
  logic          o_busy;
  logic          o_timeout;

`ifdef DEFINE_A
  modport master (output i_req, output i_done, output i_mask,
                  input o_grant, input o_grant_id, input o_busy, input o_timeout);
  modport slave  (input i_req, input i_done, input i_mask,
                  output o_grant, output o_grant_id, output o_busy, output o_timeout);
`else
  modport master (output i_req, output i_done,
                  input o_grant, input o_grant_id, input o_busy, input o_timeout);
  modport slave  (input i_req, input i_done,
                  output o_grant, output o_grant_id, output o_busy, output o_timeout);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of i_vec at or after i_ptr.
// Returns the winner as both a one-hot vector and an index.
module rr_pick
  import rr_grant_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [MAX_N-1:0] vec_w;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    vec_w          = '0;
    vec_w[N-1:0]   = i_vec;
    o_any          = |i_vec;
    o_idx          = IW'(first_from(vec_w, int'(i_ptr), N));
    o_onehot       = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = o_any && (o_idx == IW'(i));
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner of a shared port: one registered one-hot grant, released on
// done, abandon, hold-budget timeout or (DEFINE_A) mask revoke, then one idle gap.
module rr_grant_scheduler
  import rr_grant_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int IW       = $clog2(N)
) (
  input logic                 i_clk,
  input logic                 i_rst,
  rr_grant_scheduler_if.slave bus
);

  localparam int            HW        = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  mask;
  logic [N-1:0]  elig;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          done_hit, req_hit, mask_hit, at_limit;
  logic [IW-1:0] ptr_next;

`ifdef DEFINE_A
  assign mask = bus.i_mask;
`else
  assign mask = '1;
`endif

  assign elig = bus.i_req & mask;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_vec    (elig),
    .i_ptr    (ptr_q),
    .o_onehot (pick_onehot),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  // Only the owner's done/req/mask bits matter; others are ignored while busy.
  assign done_hit = bus.i_done[id_q];
  assign req_hit  = bus.i_req[id_q];
  assign mask_hit = mask[id_q];
  assign at_limit = (hold_q == HOLD_LAST);
  assign ptr_next = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    id_d      = id_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          id_d    = pick_idx;
          hold_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done_hit || !req_hit || !mask_hit || at_limit) begin
          grant_d   = '0;
          id_d      = '0;
          ptr_d     = ptr_next;
          state_d   = GAP;
          // A timeout only counts when no other release reason is present.
          timeout_d = at_limit && !done_hit && req_hit && mask_hit;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_grant_id = id_q;
  assign bus.o_busy     = (state_q == BUSY);
  assign bus.o_timeout  = timeout_q;

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one downstream resource (a single datapath port) between `N` requesters. It issues one registered one-hot grant at a time and holds it until the owner signals completion, drops its request, or exceeds a hold budget. The block sits in front of the shared port. An optional per-requester enable mask is compiled in only when `DEFINE_A` is defined, so one source serves both build flavours.

## Interface
Parameters:
- `N`, default 4: number of requesters; 2..16.
- `HOLD_MAX`, default 8: maximum grant cycles per ownership; 1..255.
- `IW`, default `$clog2(N)`: grant index width.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  N  request per requester; level, held until served.
- `i_done`  in  N  completion strobe from the owner; only the granted bit is sampled.
- `i_mask`  in  N  requester enable. Present only under `ifdef DEFINE_A`; otherwise internally all-ones.
- `o_grant`  out  N  one-hot grant, registered.
- `o_grant_id`  out  IW  index of the granted requester; valid while `o_busy`.
- `o_busy`  out  1  a grant is active.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked by the hold budget.

## Operation
- Eligible vector: `i_req & i_mask`.
- States:
  - IDLE: no grant.
  - BUSY: one grant held.
  - GAP: one cycle, no grant.
- IDLE:
  - If any bit is eligible, select the first eligible index at or after `ptr`, scanning upward with wrap modulo N.
  - Register the grant, clear `hold_cnt`, go to BUSY.
  - With none eligible, stay in IDLE.
- BUSY releases the grant when any of the following holds at a clock edge:
  - `i_done[id]` = 1: normal release.
  - `i_req[id]` = 0: abandon.
  - `hold_cnt == HOLD_MAX-1`: timeout; `o_timeout` pulses in the next cycle.
  - `i_mask[id]` = 0 (DEFINE_A build only): revoke, no timeout pulse.
- If none of these holds, `hold_cnt` increments.
- On any release: `ptr <= (id+1) mod N`, then go to GAP.
- GAP: all grants 0 for exactly one cycle, then IDLE. This guarantees a turnaround cycle on the shared port.
- Simultaneous `i_done` and timeout in the same cycle: treated as normal release, no `o_timeout`.
- `i_done` on a non-granted bit is ignored.
- Requests arriving in BUSY or GAP wait. Fairness: a continuously requesting requester is granted within N-1 other ownerships.
- `hold_cnt` width is `$clog2(HOLD_MAX+1)` and saturates; it never wraps.

## Timing
- Reset values (asynchronous): state = IDLE, `ptr` = 0, `hold_cnt` = 0; `o_grant` = 0, `o_grant_id` = 0, `o_busy` = 0, `o_timeout` = 0.
- Request-to-grant latency: 1 cycle. A request sampled in IDLE at edge k is visible as a grant after edge k.
- Maximum ownership: `HOLD_MAX` cycles of `o_busy`.
- Release-to-next-grant: 2 cycles (GAP, then IDLE evaluation).
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-grant drops `o_grant` immediately (asynchronous). On reset release, the first arbitration starts from index 0.

## Structure
- Shared package `rr_grant_pkg`: state enum (IDLE, BUSY, GAP), and a `first_from(vec, ptr)` function returning the index of the first set bit at or after `ptr`.
- One sub-module, `rr_pick`: combinational rotate-priority picker (N-bit eligible + `ptr` → one-hot + index). It is reused by other arbiters.
- `ifdef DEFINE_A` guards only the `i_mask` port declaration and its usage. Both build flavours must lint clean.

## Test plan
- Reset, then `i_req`=0001 → `o_grant`=0001 and `o_busy`=1 one cycle later; `i_done[0]` pulse → grant drops, one GAP cycle, then IDLE.
- `i_req`=1111 held, `i_done` pulsed in each grant's 3rd cycle → grant order 0,1,2,3,0; each ownership lasts 3 cycles, separated by a 1-cycle gap.
- `HOLD_MAX`=4, `i_req`=0010 held, no `i_done` → grant for exactly 4 cycles, then `o_timeout` pulses once; requester 1 is re-granted 2 cycles later.
- `i_done` and the timeout coincide on the 4th cycle → release with `o_timeout` kept at 0.
- DEFINE_A build, `i_req`=0101, `i_mask`=1011 → only requester 0 is granted. Clearing `i_mask[0]` mid-grant → revoke, no timeout pulse.
- Assert `i_rst` during BUSY with `ptr`=2 → all outputs are 0 immediately. After release with `i_req`=1111, the first grant is 0001.
